soc_bram_arbiter: RTL and testbench

//  Two-port arbiter sharing one soc_bram_ctl between the instruction-fetch port (read-only, i_*) and the data port (d_*, read/write).

---
 rtl/soc_bram_arbiter.sv | 106 ++++++++++
 tb/tb_soc_bram_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bram_arbiter.sv
// Shares one soc_bram_ctl between the instruction-fetch port (i_*) and the data port (d_*).
// Define SOC_BRAM_ARB_RR_EN for round-robin arbitration; the default is fixed data-first priority.
//
// state | meaning
// INIT  | post-reset holdoff so a ctl transaction cut off by reset can drain
// IDLE  | sample requests, latch the winner onto m_*
// BUSY  | m_valid to ctl until m_done, capture m_dread
// RESP  | one-cycle done pulse on the granted port
module soc_bram_arbiter #(
    parameter int addr_width = 8,
    parameter int HOLDOFF    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_valid,
    input  logic [addr_width-1:0] i_addr,
    output logic [31:0]           i_dread,
    output logic                  i_done,
    input  logic                  d_valid,
    input  logic                  d_rw,
    input  logic [addr_width-1:0] d_addr,
    input  logic [31:0]           d_dwrite,
    output logic [31:0]           d_dread,
    output logic                  d_done,
    output logic                  m_valid,
    output logic                  m_rw,
    output logic [addr_width-1:0] m_addr,
    output logic [31:0]           m_dwrite,
    input  logic [31:0]           m_dread,
    input  logic                  m_done
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   hold_cnt;
    logic            grant_d;
    logic            pick_d;
    logic            any_req;

    assign any_req = i_valid | d_valid;

`ifdef SOC_BRAM_ARB_RR_EN
    logic last_d;

    // On a tie the port that did not win last time gets the grant.
    assign pick_d = d_valid & (~i_valid | ~last_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = d_valid;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (hold_cnt == CW'(HOLDOFF - 1)) state_nxt = IDLE;
            IDLE: if (any_req) state_nxt = BUSY;
            BUSY: if (m_done) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            hold_cnt <= '0;
            grant_d  <= 1'b0;
            m_rw     <= 1'b0;
            m_addr   <= '0;
            m_dwrite <= '0;
            i_dread  <= '0;
            d_dread  <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                hold_cnt <= hold_cnt + CW'(1);
            end
            if (state == IDLE && any_req) begin
                grant_d  <= pick_d;
                m_addr   <= pick_d ? d_addr : i_addr;
                m_rw     <= pick_d & d_rw;
                m_dwrite <= pick_d ? d_dwrite : '0;
            end
            if (state == BUSY && m_done) begin
                if (grant_d) d_dread <= m_dread;
                else         i_dread <= m_dread;
            end
        end
    end

    // ctl restarts if valid is still high in its done cycle, so mask it combinationally.
    assign m_valid = (state == BUSY) & ~m_done;
    assign i_done  = (state == RESP) & ~grant_d;
    assign d_done  = (state == RESP) & grant_d;

endmodule

// File: tb/tb_soc_bram_arbiter.sv
// Directed bench for soc_bram_arbiter with a 3-cycle byte-addressed ctl model and a scoreboard
// of expected grants/read data.
module tb_soc_bram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid, d_valid, d_rw;
    logic [7:0]  i_addr, d_addr, m_addr;
    logic [31:0] d_dwrite, i_dread, d_dread, m_dwrite, m_dread;
    logic        i_done, d_done, m_valid, m_rw, m_done;
    logic        ctl_done, force_done;
    logic [1:0]  ctl_cnt;
    logic [7:0]  mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          port;
        bit          rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] mask;
    } exp_t;

    exp_t sb[$];

    soc_bram_arbiter #(.addr_width(8), .HOLDOFF(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_valid(i_valid), .i_addr(i_addr), .i_dread(i_dread), .i_done(i_done),
        .d_valid(d_valid), .d_rw(d_rw), .d_addr(d_addr), .d_dwrite(d_dwrite),
        .d_dread(d_dread), .d_done(d_done),
        .m_valid(m_valid), .m_rw(m_rw), .m_addr(m_addr), .m_dwrite(m_dwrite),
        .m_dread(m_dread), .m_done(m_done)
    );

    always #5 clk = ~clk;

    // ctl model: done one cycle after the third consecutive valid cycle, little-endian bytes, no reset
    initial ctl_cnt = 2'd0;
    initial ctl_done = 1'b0;
    always @(posedge clk) begin
        if (m_valid) begin
            if (ctl_cnt == 2'd2) begin
                ctl_cnt  <= 2'd0;
                ctl_done <= 1'b1;
                m_dread  <= {mem[8'(m_addr + 8'd3)], mem[8'(m_addr + 8'd2)],
                             mem[8'(m_addr + 8'd1)], mem[m_addr]};
                if (m_rw) begin
                    mem[m_addr]               <= m_dwrite[7:0];
                    mem[8'(m_addr + 8'd1)]    <= m_dwrite[15:8];
                    mem[8'(m_addr + 8'd2)]    <= m_dwrite[23:16];
                    mem[8'(m_addr + 8'd3)]    <= m_dwrite[31:24];
                end
            end else begin
                ctl_cnt  <= ctl_cnt + 2'd1;
                ctl_done <= 1'b0;
            end
        end else begin
            ctl_cnt  <= 2'd0;
            ctl_done <= 1'b0;
        end
    end

    assign m_done = ctl_done | force_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for a port done, compares it with the scoreboard head and drops that port's valid.
    task automatic wait_done(output int lat, output bit port);
        exp_t e;
        bit   seen_mv = 1'b0;
        lat  = 0;
        port = 1'b0;
        while (lat < 50) begin
            if (m_valid && !seen_mv && sb.size() > 0) begin
                seen_mv = 1'b1;
                check("m_rw", {31'd0, m_rw}, {31'd0, sb[0].rw});
                check("m_addr", {24'd0, m_addr}, {24'd0, sb[0].addr});
                check("m_dwrite", m_dwrite, sb[0].wdata);
            end
            if (i_done || d_done) break;
            tick();
            lat++;
        end
        if (!(i_done || d_done)) begin
            check("done_timeout", 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e    = sb.pop_front();
            port = d_done;
            check("dual_done", {31'd0, i_done & d_done}, 32'd0);
            check("done_port", {31'd0, d_done}, {31'd0, e.port});
            if (e.mask != 32'd0)
                check(e.port ? "d_dread" : "i_dread", (e.port ? d_dread : i_dread) & e.mask,
                      e.rdata & e.mask);
            if (port) d_valid = 1'b0;
            else      i_valid = 1'b0;
        end
    endtask

    task automatic txn(input bit port, input bit rw, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [31:0] mask, input int exp_lat);
        int lat;
        bit p;
        sb.push_back('{port, port & rw, addr, port ? wd : 32'd0, rd, mask});
        if (port) begin
            d_valid = 1'b1; d_rw = rw; d_addr = addr; d_dwrite = wd;
        end else begin
            i_valid = 1'b1; i_addr = addr;
        end
        wait_done(lat, p);
        if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
        tick();
    endtask

    initial begin
        int  cyc;
        int  lat;
        bit  p;
        bit  stray;
        int  i_left, d_left;

        reset_n = 1'b0; force_done = 1'b0;
        i_valid = 1'b0; i_addr = 8'h00;
        d_valid = 1'b1; d_rw = 1'b1; d_addr = 8'h10; d_dwrite = 32'hDEADBEEF;

        // 1: holdoff after reset with a data write pending the whole time
        tick();
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_dones", {30'd0, i_done, d_done}, 32'd0);
        check("rst_m_addr", {24'd0, m_addr}, 32'd0);
        check("rst_m_dwrite", m_dwrite, 32'd0);
        check("rst_d_dread", d_dread, 32'd0);
        tick(); tick();
        sb.push_back('{1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'd0, 32'd0});
        reset_n = 1'b1;
        cyc = 0;
        while (!m_valid && cyc < 20) begin
            check("holdoff_no_mvalid", {31'd0, m_valid}, 32'd0);
            tick();
            cyc++;
        end
        check("holdoff_cycles", 32'(cyc), 32'd5);
        wait_done(lat, p);
        tick();

        // 2: read back with latency, plus a second word for the contention test
        txn(1'b1, 1'b0, 8'h10, 32'd0, 32'hDEADBEEF, 32'hFFFFFFFF, 5);
        txn(1'b1, 1'b1, 8'h20, 32'h12345678, 32'd0, 32'd0, 5);

        // 3: unaligned data read and fetch read
        txn(1'b1, 1'b0, 8'h11, 32'd0, 32'h00DEADBE, 32'h00FFFFFF, 5);
        txn(1'b0, 1'b0, 8'h10, 32'd0, 32'hDEADBEEF, 32'hFFFFFFFF, 5);
        check("i_dread_hold", i_dread, 32'hDEADBEEF);
        check("d_dread_hold", d_dread[23:0], 24'hDEADBE);

        // 5: stray ctl done in IDLE
        force_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stray_idle", {29'd0, i_done, d_done, m_valid}, 32'd0);
        end
        force_done = 1'b0;
        tick();
        txn(1'b0, 1'b0, 8'h20, 32'd0, 32'h12345678, 32'hFFFFFFFF, 5);

        // 6: reset during a busy data write
        d_valid = 1'b1; d_rw = 1'b1; d_addr = 8'h30; d_dwrite = 32'hCAFEF00D;
        tick(); tick();
        check("busy_m_valid", {31'd0, m_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {29'd0, m_valid, m_rw, d_done}, 32'd0);
        check("abort_m_addr", {24'd0, m_addr}, 32'd0);
        tick();
        reset_n = 1'b1;
        d_valid = 1'b0;
        force_done = 1'b1;
        stray = 1'b0;
        tick();
        force_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            stray |= i_done | d_done | m_valid;
            tick();
        end
        check("abort_no_done", {31'd0, stray}, 32'd0);
        txn(1'b1, 1'b0, 8'h10, 32'd0, 32'hDEADBEEF, 32'hFFFFFFFF, 5);

        // 4: contention from a fresh reset, both ports re-requesting after each completion
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        i_valid = 1'b1; i_addr = 8'h10;
        d_valid = 1'b1; d_rw = 1'b0; d_addr = 8'h20;
        for (int k = 0; k < 4; k++) begin
`ifdef SOC_BRAM_ARB_RR_EN
            p = (k % 2) == 1;
`else
            p = (k % 2) == 0;
`endif
            if (p) sb.push_back('{1'b1, 1'b0, 8'h20, 32'd0, 32'h12345678, 32'hFFFFFFFF});
            else   sb.push_back('{1'b0, 1'b0, 8'h10, 32'd0, 32'hDEADBEEF, 32'hFFFFFFFF});
        end
        i_left = 2;
        d_left = 2;
        for (int k = 0; k < 4; k++) begin
            wait_done(lat, p);
            if (p) d_left--;
            else   i_left--;
            tick();
            tick();
            if (p && d_left > 0)  d_valid = 1'b1;
            if (!p && i_left > 0) i_valid = 1'b1;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
